// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and constants for the memory port arbiter
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_GNT_IF = 2'd1,
        ARB_GNT_D  = 2'd2,
        ARB_RESP   = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_D  = 1'b1
    } arb_owner_e;

    localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
    localparam logic [3:0]  SEL_ALL       = 4'b1111;
    localparam logic [3:0]  SEL_NONE      = 4'b0000;
    localparam logic        WRITE_ENABLE  = 1'b1;
    localparam logic        WRITE_DISABLE = 1'b0;

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for one 32-bit memory port with timeout abort
// Optional round-robin tie-break on simultaneous requests: MEM_ARB_RR_EN
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_sel,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_sel,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stallreq_if,
    output logic        stallreq_mem,
    output logic        bus_err
);

    localparam bit              TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES != 0) ? TIMEOUT_CYCLES - 1 : 0);

    arb_state_e        state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [3:0]        mem_sel_q, mem_sel_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       d_rdata_q, d_rdata_d;
    logic              bus_err_q, bus_err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              grant_data;
    logic [31:0]       resp_data;
    arb_owner_e        owner;
`ifdef MEM_ARB_RR_EN
    arb_owner_e        last_grant_q, last_grant_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= WRITE_DISABLE;
            mem_sel_q   <= SEL_NONE;
            mem_addr_q  <= ZERO_WORD;
            mem_wdata_q <= ZERO_WORD;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            if_rdata_q  <= ZERO_WORD;
            d_rdata_q   <= ZERO_WORD;
            bus_err_q   <= 1'b0;
            cnt_q       <= '0;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= OWNER_IF;
`endif
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_sel_q   <= mem_sel_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            bus_err_q   <= bus_err_d;
            cnt_q       <= cnt_d;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_sel_d   = mem_sel_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        bus_err_d   = bus_err_q;
        cnt_d       = cnt_q;
        resp_data   = ZERO_WORD;
        owner       = (state_q == ARB_GNT_D) ? OWNER_D : OWNER_IF;
`ifdef MEM_ARB_RR_EN
        last_grant_d = last_grant_q;
        // On a tie, hand the port to whoever did not have it last time
        grant_data   = d_req && (!if_req || (last_grant_q == OWNER_IF));
`else
        grant_data   = d_req;
`endif

        case (state_q)
            ARB_IDLE: begin
                if (grant_data) begin
                    state_d     = ARB_GNT_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_sel_d   = d_sel;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    cnt_d       = '0;
`ifdef MEM_ARB_RR_EN
                    last_grant_d = OWNER_D;
`endif
                end else if (if_req) begin
                    state_d     = ARB_GNT_IF;
                    mem_req_d   = 1'b1;
                    mem_we_d    = WRITE_DISABLE;
                    mem_sel_d   = SEL_ALL;
                    mem_addr_d  = if_addr;
                    cnt_d       = '0;
`ifdef MEM_ARB_RR_EN
                    last_grant_d = OWNER_IF;
`endif
                end
            end
            ARB_GNT_IF, ARB_GNT_D: begin
                // A real completion in the final timeout cycle still wins over the abort
                if (mem_ack || (TO_EN && (cnt_q == TO_LAST))) begin
                    state_d   = ARB_RESP;
                    mem_req_d = 1'b0;
                    resp_data = mem_ack ? mem_rdata : ZERO_WORD;
                    if (!mem_ack) begin
                        bus_err_d = 1'b1;
                    end
                    if (owner == OWNER_D) begin
                        d_ack_d = 1'b1;
                        if (!mem_ack || (mem_we_q == WRITE_DISABLE)) begin
                            d_rdata_d = resp_data;
                        end
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = resp_data;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_sel      = mem_sel_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign if_ack       = if_ack_q;
    assign d_ack        = d_ack_q;
    assign if_rdata     = if_rdata_q;
    assign d_rdata      = d_rdata_q;
    assign bus_err      = bus_err_q;
    assign stallreq_if  = if_req & ~if_ack_q;
    assign stallreq_mem = d_req & ~d_ack_q;

endmodule
